// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and the fetch FSM state type.
package pipeline_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        FS_REQ,
        FS_WAIT,
        FS_HOLD
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry {pc, inst} buffer that parks a fetch response arriving while ID is stalled.
module fetch_hold_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] held_pc,
    output logic [XLEN-1:0] held_inst,
    output logic            valid
);

    // A redirect clears the entry even if a load is requested in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_pc   <= '0;
            held_inst <= '0;
            valid     <= 1'b0;
        end else if (clear) begin
            valid     <= 1'b0;
        end else if (load) begin
            held_pc   <= pc;
            held_inst <= inst;
            valid     <= 1'b1;
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// Fetch front end and IF/ID pipeline register with one outstanding instruction read.
// Optional IF_PERF_CNT_EN adds saturating stall/flush cycle counters.
module if_id_stage
    import pipeline_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            is_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ID_pc,
    output logic [XLEN-1:0] ID_inst,
    output logic            ID_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt
`endif
);

    fetch_state_e    state, state_d;
    logic [XLEN-1:0] pc_q, pc_d, pc_inc;
    logic            drop, drop_d;
    logic            id_load, id_bubble, id_valid_d;
    logic [XLEN-1:0] id_pc_d, id_inst_d;
    logic            buf_load, buf_clear, buf_valid;
    logic [XLEN-1:0] buf_pc, buf_inst;

    assign pc_inc = pc_q + XLEN'(4);

    fetch_hold_buf #(.XLEN(XLEN)) u_hold_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (buf_load),
        .clear     (buf_clear),
        .pc        (pc_q),
        .inst      (imem_rdata),
        .held_pc   (buf_pc),
        .held_inst (buf_inst),
        .valid     (buf_valid)
    );

    always_comb begin
        state_d    = state;
        pc_d       = pc_q;
        drop_d     = drop;
        imem_req   = 1'b0;
        imem_addr  = pc_q;
        id_load    = 1'b0;
        id_bubble  = 1'b0;
        id_valid_d = 1'b1;
        id_pc_d    = pc_q;
        id_inst_d  = imem_rdata;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        if (redirect_valid) begin
            id_bubble = 1'b1;
            buf_clear = 1'b1;
            pc_d      = redirect_pc & ~XLEN'(3);
            // A request still in flight must have its late response thrown away.
            if (state == FS_WAIT && !imem_rvalid) begin
                drop_d = 1'b1;
            end else begin
                drop_d  = 1'b0;
                state_d = FS_REQ;
            end
        end else begin
            case (state)
                FS_REQ: begin
                    if (!is_stall) begin
                        imem_req = 1'b1;
                        state_d  = FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop_d  = 1'b0;
                            state_d = FS_REQ;
                        end else if (!is_stall) begin
                            id_load   = 1'b1;
                            imem_req  = 1'b1;
                            imem_addr = pc_inc;
                            pc_d      = pc_inc;
                        end else begin
                            buf_load = 1'b1;
                            state_d  = FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (!is_stall) begin
                        id_load    = 1'b1;
                        id_valid_d = buf_valid;
                        id_pc_d    = buf_pc;
                        id_inst_d  = buf_inst;
                        buf_clear  = 1'b1;
                        pc_d       = pc_inc;
                        state_d    = FS_REQ;
                    end
                end
                default: state_d = FS_REQ;
            endcase
            if (!is_stall && !id_load) id_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FS_REQ;
            pc_q  <= RESET_PC;
            drop  <= 1'b0;
        end else begin
            state <= state_d;
            pc_q  <= pc_d;
            drop  <= drop_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ID_pc    <= '0;
            ID_inst  <= NOP_INST;
            ID_valid <= 1'b0;
        end else if (id_load) begin
            ID_pc    <= id_pc_d;
            ID_inst  <= id_inst_d;
            ID_valid <= id_valid_d;
        end else if (id_bubble) begin
            ID_inst  <= NOP_INST;
            ID_valid <= 1'b0;
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (is_stall && perf_stall_cnt != '1)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (redirect_valid && perf_flush_cnt != '1)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus a randomized run scored
// against a program-order model of delivered instructions and fetch addresses.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] ID_pc;
    logic [31:0] ID_inst;
    logic        ID_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int lat_min  = 1;
    int lat_max  = 1;

    if_id_stage dut (
        .clk            (clk),
        .rst            (rst),
        .is_stall       (is_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .ID_pc          (ID_pc),
        .ID_inst        (ID_inst),
        .ID_valid       (ID_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return (a * 32'd7) ^ 32'hC0DE_0001;
    endfunction

    // In-order instruction memory, one request in flight, latency drawn from [lat_min, lat_max].
    initial begin : memory
        logic        pend;
        logic [31:0] pend_addr;
        int          pend_cnt;
        pend = 1'b0; pend_addr = '0; pend_cnt = 0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_rvalid = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = inst_of(pend_addr);
                    pend        = 1'b0;
                end
            end
            #3;
            if (!rst && imem_req) begin
                n_checks++;
                if (pend) begin
                    n_fail++;
                    $display("FAIL mem_one_outstanding: got second request addr %h, required none while %h pending", imem_addr, pend_addr);
                end
                pend      = 1'b1;
                pend_addr = imem_addr;
                pend_cnt  = $urandom_range(lat_min, lat_max);
            end
        end
    end

    task automatic drive(input logic s, input logic r, input logic [31:0] rp);
        @(negedge clk);
        is_stall       = s;
        redirect_valid = r;
        redirect_pc    = rp;
        #2;
    endtask

    task automatic do_reset(input int lmin, input int lmax);
        @(negedge clk);
        rst = 1'b1; is_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        lat_min = lmin; lat_max = lmax;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
    endtask

    task automatic test_reset();
        do_reset(1, 1);
        repeat (5) drive(0, 0, 0);
        do_reset(1, 1);
        n_checks++;
        if (ID_valid !== 1'b0 || ID_inst !== NOP || ID_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_id: got v=%b pc=%h inst=%h, required v=0 pc=0 inst=%h", ID_valid, ID_pc, ID_inst, NOP);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_first_req: got req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
        end
    endtask

    task automatic test_stream();
        do_reset(1, 1);
        drive(0, 0, 0);
        n_checks++;
        if (ID_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_latency: got ID_valid=%b one cycle after release, required 0", ID_valid);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0);
            n_checks++;
            if (ID_valid !== 1'b1 || ID_pc !== 32'(4 * i) || ID_inst !== inst_of(32'(4 * i))) begin
                n_fail++;
                $display("FAIL stream_id[%0d]: got v=%b pc=%h inst=%h, required v=1 pc=%h inst=%h",
                         i, ID_valid, ID_pc, ID_inst, 32'(4 * i), inst_of(32'(4 * i)));
            end
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i + 8)) begin
                n_fail++;
                $display("FAIL stream_req[%0d]: got req=%b addr=%h, required req=1 addr=%h", i, imem_req, imem_addr, 32'(4 * i + 8));
            end
        end
    endtask

    task automatic test_stall();
        do_reset(1, 1);
        repeat (3) drive(0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            drive(c < 3, 0, 0);
            n_checks++;
            if (ID_valid !== 1'b1 || ID_pc !== 32'h8 || ID_inst !== inst_of(32'h8)) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h, required v=1 pc=8 inst=%h", c, ID_valid, ID_pc, ID_inst, inst_of(32'h8));
            end
            n_checks++;
            if (imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_no_req[%0d]: got req=%b, required 0", c, imem_req);
            end
        end
        drive(0, 0, 0);
        n_checks++;
        if (ID_valid !== 1'b1 || ID_pc !== 32'hC || ID_inst !== inst_of(32'hC)) begin
            n_fail++;
            $display("FAIL stall_resume: got v=%b pc=%h inst=%h, required v=1 pc=c", ID_valid, ID_pc, ID_inst);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            n_fail++;
            $display("FAIL stall_resume_req: got req=%b addr=%h, required req=1 addr=10", imem_req, imem_addr);
        end
        drive(1, 0, 0);
        drive(0, 0, 0);
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release_req: got req=%b, required 0", imem_req);
        end
        drive(0, 0, 0);
        n_checks++;
        if (ID_valid !== 1'b1 || ID_pc !== 32'h10 || ID_inst !== inst_of(32'h10)) begin
            n_fail++;
            $display("FAIL hold_deliver: got v=%b pc=%h inst=%h, required v=1 pc=10", ID_valid, ID_pc, ID_inst);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
            n_fail++;
            $display("FAIL hold_next_req: got req=%b addr=%h, required req=1 addr=14", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_drop();
        logic        exp_req;
        logic [31:0] exp_addr;
        do_reset(3, 3);
        for (int c = 2; c <= 13; c++) begin
            drive(0, (c == 2 || c == 6), (c == 2) ? 32'h40 : 32'h100);
            exp_req  = (c == 5 || c == 9 || c == 12);
            exp_addr = (c == 5) ? 32'h40 : (c == 9) ? 32'h100 : 32'h104;
            n_checks++;
            if (imem_req !== exp_req || (exp_req && imem_addr !== exp_addr)) begin
                n_fail++;
                $display("FAIL drop_req[c%0d]: got req=%b addr=%h, required req=%b addr=%h", c, imem_req, imem_addr, exp_req, exp_addr);
            end
            n_checks++;
            if (c < 13 && ID_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL drop_bubble[c%0d]: got v=%b pc=%h, required v=0", c, ID_valid, ID_pc);
            end else if (c == 13 && (ID_valid !== 1'b1 || ID_pc !== 32'h100 || ID_inst !== inst_of(32'h100))) begin
                n_fail++;
                $display("FAIL drop_target: got v=%b pc=%h inst=%h, required v=1 pc=100", ID_valid, ID_pc, ID_inst);
            end
        end
    endtask

    task automatic test_redirect_stall();
        do_reset(1, 1);
        repeat (2) drive(0, 0, 0);
        drive(1, 1, 32'h203);
        n_checks++;
        if (imem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_stall_req: got req=%b, required 0", imem_req);
        end
        drive(0, 0, 0);
        n_checks++;
        if (ID_valid !== 1'b0 || ID_inst !== NOP) begin
            n_fail++;
            $display("FAIL redir_stall_flush: got v=%b inst=%h, required v=0 inst=%h", ID_valid, ID_inst, NOP);
        end
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_fail++;
            $display("FAIL redir_stall_addr: got req=%b addr=%h, required req=1 addr=200", imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        do_reset(1, 1);
        drive(0, 1, 32'hFFFF_FFFC);
        drive(0, 0, 0);
        drive(0, 0, 0);
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr: got req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
        end
        drive(0, 0, 0);
        n_checks++;
        if (ID_valid !== 1'b1 || ID_pc !== 32'hFFFF_FFFC || ID_inst !== inst_of(32'hFFFF_FFFC)) begin
            n_fail++;
            $display("FAIL wrap_id: got v=%b pc=%h inst=%h, required v=1 pc=fffffffc", ID_valid, ID_pc, ID_inst);
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        do_reset(1, 1);
        n_checks++;
        if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_reset: got stall=%0d flush=%0d, required 0 0", perf_stall_cnt, perf_flush_cnt);
        end
        repeat (5) drive(1, 0, 0);
        repeat (2) drive(0, 1, 32'h10);
        drive(0, 0, 0);
        n_checks++;
        if (perf_stall_cnt !== 32'd5 || perf_flush_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_count: got stall=%0d flush=%0d, required 5 2", perf_stall_cnt, perf_flush_cnt);
        end
    endtask
`endif

    // Program-order model: deliveries must walk exp_pc in steps of 4, fetches walk exp_fetch,
    // and both restart at the aligned target of every redirect.
    task automatic test_random();
        logic [31:0] exp_pc, exp_fetch, ppc, pinst, prpc, rp;
        logic        pv, ps, pr, s, r;
        int          delivered;
        do_reset(1, 3);
        exp_pc = 32'h0; exp_fetch = 32'h0; delivered = 0;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_fetch) begin
            n_fail++;
            $display("FAIL rand_first_req: got req=%b addr=%h, required req=1 addr=%h", imem_req, imem_addr, exp_fetch);
        end
        exp_fetch = 32'h4;
        ps = 1'b0; pr = 1'b0; prpc = '0;
        pv = ID_valid; ppc = ID_pc; pinst = ID_inst;
        for (int k = 0; k < 600; k++) begin
            s  = ($urandom_range(0, 99) < 30);
            r  = ($urandom_range(0, 99) < 8);
            rp = 32'($urandom_range(0, 32'hFFF));
            drive(s, r, rp);
            n_checks++;
            if (pr) begin
                exp_pc = prpc & ~32'h3;
                if (ID_valid !== 1'b0 || ID_inst !== NOP) begin
                    n_fail++;
                    $display("FAIL rand_flush[%0d]: got v=%b inst=%h, required v=0 inst=%h", k, ID_valid, ID_inst, NOP);
                end
            end else if (ps) begin
                if (ID_valid !== pv || ID_pc !== ppc || ID_inst !== pinst) begin
                    n_fail++;
                    $display("FAIL rand_stall_hold[%0d]: got v=%b pc=%h inst=%h, required v=%b pc=%h inst=%h",
                             k, ID_valid, ID_pc, ID_inst, pv, ppc, pinst);
                end
            end else if (ID_valid === 1'b1) begin
                if (ID_pc !== exp_pc || ID_inst !== inst_of(exp_pc)) begin
                    n_fail++;
                    $display("FAIL rand_deliver[%0d]: got pc=%h inst=%h, required pc=%h inst=%h", k, ID_pc, ID_inst, exp_pc, inst_of(exp_pc));
                end
                exp_pc = exp_pc + 32'h4;
                delivered++;
            end else if (ID_inst !== NOP || ID_pc !== ppc) begin
                n_fail++;
                $display("FAIL rand_bubble[%0d]: got pc=%h inst=%h, required pc=%h inst=%h", k, ID_pc, ID_inst, ppc, NOP);
            end
            n_checks++;
            if ((s || r) && imem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_req_blocked[%0d]: got req=%b, required 0", k, imem_req);
            end else if (!(s || r) && imem_req === 1'b1) begin
                if (imem_addr !== exp_fetch) begin
                    n_fail++;
                    $display("FAIL rand_fetch_addr[%0d]: got %h, required %h", k, imem_addr, exp_fetch);
                end
                exp_fetch = exp_fetch + 32'h4;
            end
            if (r) exp_fetch = rp & ~32'h3;
            ps = s; pr = r; prpc = rp;
            pv = ID_valid; ppc = ID_pc; pinst = ID_inst;
        end
        n_checks++;
        if (delivered < 40) begin
            n_fail++;
            $display("FAIL rand_progress: got %0d deliveries, required at least 40", delivered);
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; is_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        #2;
        n_checks++;
        if (ID_valid !== 1'b0 || ID_inst !== NOP || ID_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async: got v=%b pc=%h inst=%h, required v=0 pc=0 inst=%h", ID_valid, ID_pc, ID_inst, NOP);
        end
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_stall();
        test_wrap();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
